// File: rtl/mips_io_pkg.sv
// Shared register map and defaults for the MIPS memory-mapped I/O port.
package mips_io_pkg;

  localparam logic [1:0] OFS_OUT    = 2'd0;
  localparam logic [1:0] OFS_IN     = 2'd1;
  localparam logic [1:0] OFS_STATUS = 2'd2;
  localparam logic [1:0] OFS_CTRL   = 2'd3;

  localparam int STATUS_CHG  = 0;
  localparam int CTRL_IRQ_EN = 0;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF0000;

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchronizer followed by a whole-vector debouncer; commit pulses on the edge deb updates.
module io_debouncer #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pinIn,
  output logic [WIDTH-1:0] deb,
  output logic             commit
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  // Combinational so the owner can set its sticky flag on the same edge deb changes.
  assign commit = (s2 == cand) && (cnt == CNT_MAX) && (deb != cand);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      cnt  <= '0;
      deb  <= '0;
    end else begin
      s1 <= pinIn;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else if (commit) begin
        deb <= cand;
      end
    end
  end

endmodule

// File: rtl/mips_io_port.sv
// Memory-mapped I/O window on the MIPS data bus: output register, debounced input,
// sticky change flag with optional interrupt.
module mips_io_port
  import mips_io_pkg::*;
#(
  parameter int          IN_WIDTH        = 8,
  parameter int          OUT_WIDTH       = 32,
  parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  output logic [31:0]          ReadData,
  output logic                 io_hit,
  input  logic [IN_WIDTH-1:0]  PortIn,
  output logic [OUT_WIDTH-1:0] PortOut,
  output logic                 change_irq
);

  logic [IN_WIDTH-1:0]  deb;
  logic                 commit;
  logic [OUT_WIDTH-1:0] outReg;
  logic                 chgFlag;
  logic                 irqEn;
  logic                 wrEn;
  logic [1:0]           regSel;
  logic [31:0]          readSel;

  io_debouncer #(
    .WIDTH  (IN_WIDTH),
    .CYCLES (DEBOUNCE_CYCLES)
  ) uDebouncer (
    .clk    (clk),
    .reset  (reset),
    .pinIn  (PortIn),
    .deb    (deb),
    .commit (commit)
  );

  // Only word-aligned addresses inside the 16-byte window are mapped.
  assign io_hit  = (Address[31:4] == IO_BASE[31:4]) && (Address[1:0] == 2'b00);
  assign regSel  = Address[3:2];
  assign wrEn    = MemWrite & io_hit;
  assign PortOut = outReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outReg     <= '0;
      chgFlag    <= 1'b0;
      irqEn      <= 1'b0;
      change_irq <= 1'b0;
    end else begin
      if (wrEn && (regSel == OFS_OUT))
        outReg <= WriteData[OUT_WIDTH-1:0];
      if (wrEn && (regSel == OFS_CTRL))
        irqEn <= WriteData[CTRL_IRQ_EN];
      // A commit on the same edge as a write-1-to-clear keeps the flag set.
      if (commit)
        chgFlag <= 1'b1;
      else if (wrEn && (regSel == OFS_STATUS) && WriteData[STATUS_CHG])
        chgFlag <= 1'b0;
      change_irq <= chgFlag & irqEn;
    end
  end

  always_comb begin
    readSel = 32'h0;
    case (regSel)
      OFS_OUT:    readSel = 32'(outReg);
      OFS_IN:     readSel = 32'(deb);
      OFS_STATUS: readSel[STATUS_CHG] = chgFlag;
      OFS_CTRL:   readSel[CTRL_IRQ_EN] = irqEn;
      default:    readSel = 32'h0;
    endcase
    ReadData = (MemRead && io_hit) ? readSel : 32'h0;
  end

endmodule
